dbus_bridge16: RTL and testbench

Data-side bus bridge between the Polaris CPU D master port and the 16-bit system bus. It accepts one 64-bit-wide CPU load or store request, with byte, half, word or dword size, and splits it into 1, 2 or 4 little-endian 16-bit bus beats. For loads it assembles and zero- or sign-extends the result, then returns a single-cycle acknowledge to the CPU. It sits directly downstream of the CPU D master; the I master is not handled here.

---
 rtl/dbus_bridge16.sv | 164 ++++++++++++++++
 tb/tb_dbus_bridge16.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dbus_bridge16.sv
// dbus_bridge16: splits one CPU data request (byte/half/word/dword) into
// 1, 2 or 4 little-endian 16-bit bus beats and returns a one-cycle dack_o.
// Latency: bus cycle starts the cycle after accept; dack_o comes N+1 cycles
// after accept with a zero-wait bus (N = beat count), +1 per wait state.
// Backpressure: wack_i paces the beats; CPU inputs are ignored while busy.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   dadr_i .. dsigned_i  CPU request (address, store data, we, cyc, stb, size, sign)
//   ddat_o, dack_o       load result (held until the next completion), done pulse
//   wadr_o .. wstb_o     registered 16-bit bus master outputs
//   wdat_i, wack_i       bus read data and beat acknowledge
module dbus_bridge16 (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] dadr_i,
  input  logic [63:0] ddat_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dsigned_i,
  output logic [63:0] ddat_o,
  output logic        dack_o,
  output logic [62:0] wadr_o,
  output logic [15:0] wdat_o,
  input  logic [15:0] wdat_i,
  output logic [1:0]  wsel_o,
  output logic        wwe_o,
  output logic        wcyc_o,
  output logic        wstb_o,
  input  logic        wack_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] dat_q;     // latched store data
  logic [63:0] acc_q;     // load data assembled so far
  logic [63:0] acc_d;     // acc_q with the current beat merged in
  logic        we_q;
  logic        sgn_q;
  logic [1:0]  siz_q;
  logic        lane_q;    // byte lane for byte accesses (address bit 0)
  logic [1:0]  beat_q;
  logic        accept;
  logic        beat_ack;
  logic        last_beat;
  logic [62:0] hw_base;   // naturally aligned halfword address of the request

  // Index of the final beat: byte/half 0, word 1, dword 3.
  function automatic logic [1:0] last_idx(input logic [1:0] siz);
    case (siz)
      2'd2:    last_idx = 2'd1;
      2'd3:    last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  endfunction

  // Byte stores replicate the byte on both lanes so wsel_o alone picks the lane.
  function automatic logic [15:0] beat_data(input logic [63:0] dat,
                                            input logic [1:0]  siz,
                                            input logic [1:0]  k);
    if (siz == 2'd0) beat_data = {dat[7:0], dat[7:0]};
    else             beat_data = dat[{k, 4'b0000} +: 16];
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] raw,
                                         input logic [1:0]  siz,
                                         input logic        sgn);
    case (siz)
      2'd0:    extend = {{56{sgn & raw[7]}},  raw[7:0]};
      2'd1:    extend = {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    extend = {{32{sgn & raw[31]}}, raw[31:0]};
      default: extend = raw;
    endcase
  endfunction

  // Alignment works on the halfword address: byte address bit 0 is already
  // gone, so word clears one more bit and dword two more.
  always_comb begin
    hw_base = dadr_i[63:1];
    if (dsiz_i == 2'd2) hw_base[0]   = 1'b0;
    if (dsiz_i == 2'd3) hw_base[1:0] = 2'b00;
  end

  always_comb begin
    acc_d = acc_q;
    if (siz_q == 2'd0) acc_d[7:0] = lane_q ? wdat_i[15:8] : wdat_i[7:0];
    else               acc_d[{beat_q, 4'b0000} +: 16] = wdat_i;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    beat_ack  = 1'b0;
    last_beat = (beat_q == last_idx(siz_q));
    case (state_q)
      IDLE: if (dcyc_i && dstb_i) begin
        accept  = 1'b1;
        state_d = BUS;
      end
      BUS: if (wack_i) begin
        beat_ack = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      dat_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      siz_q   <= 2'd0;
      lane_q  <= 1'b0;
      beat_q  <= 2'd0;
      ddat_o  <= '0;
      dack_o  <= 1'b0;
      wadr_o  <= '0;
      wdat_o  <= '0;
      wsel_o  <= 2'b00;
      wwe_o   <= 1'b0;
      wcyc_o  <= 1'b0;
      wstb_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      dack_o  <= (state_d == DONE);
      if (accept) begin
        dat_q  <= ddat_i;
        acc_q  <= '0;
        we_q   <= dwe_i;
        sgn_q  <= dsigned_i;
        siz_q  <= dsiz_i;
        lane_q <= dadr_i[0];
        beat_q <= 2'd0;
        wcyc_o <= 1'b1;
        wstb_o <= 1'b1;
        wwe_o  <= dwe_i;
        wadr_o <= hw_base;
        wdat_o <= beat_data(ddat_i, dsiz_i, 2'd0);
        wsel_o <= (dsiz_i != 2'd0) ? 2'b11 : (dadr_i[0] ? 2'b10 : 2'b01);
      end
      if (beat_ack) begin
        acc_q  <= acc_d;
        beat_q <= beat_q + 2'd1;
        if (last_beat) begin
          wcyc_o <= 1'b0;
          wstb_o <= 1'b0;
          wwe_o  <= 1'b0;
          if (!we_q) ddat_o <= extend(acc_d, siz_q, sgn_q);
        end else begin
          wadr_o <= wadr_o + 63'd1;
          wdat_o <= beat_data(dat_q, siz_q, beat_q + 2'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_bridge16.sv
module tb_dbus_bridge16;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] dadr_i, ddat_i;
  logic        dwe_i, dcyc_i, dstb_i, dsigned_i;
  logic [1:0]  dsiz_i;
  logic [63:0] ddat_o;
  logic        dack_o;
  logic [62:0] wadr_o;
  logic [15:0] wdat_o, wdat_i;
  logic [1:0]  wsel_o;
  logic        wwe_o, wcyc_o, wstb_o, wack_i;

  always #5 clk_i = ~clk_i;

  dbus_bridge16 dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dadr_i(dadr_i), .ddat_i(ddat_i), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
    .dstb_i(dstb_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
    .ddat_o(ddat_o), .dack_o(dack_o),
    .wadr_o(wadr_o), .wdat_o(wdat_o), .wdat_i(wdat_i), .wsel_o(wsel_o),
    .wwe_o(wwe_o), .wcyc_o(wcyc_o), .wstb_o(wstb_o), .wack_i(wack_i)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          dack_cnt = 0;
  int          exp_dacks = 0;
  logic [63:0] exp_ddat = '0;
  int          waits[4];
  logic [15:0] mem [logic [62:0]];

  always @(posedge clk_i) if (dack_o === 1'b1) dack_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Bus memory: explicit entries, otherwise a fixed scramble of the address.
  function automatic logic [15:0] memhw(input logic [62:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A3C;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [63:0] b);
    logic [15:0] h;
    h = memhw(b[63:1]);
    return b[0] ? h[15:8] : h[7:0];
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ddat"}, ddat_o, 64'd0);
    chk({tag, "_ack"},  {63'd0, dack_o}, 64'd0);
    chk({tag, "_bus"},  {wadr_o, wdat_o, wsel_o, wwe_o, wcyc_o, wstb_o}, '0);
  endtask

  // Runs one CPU transaction; entered and left at #1 after a rising edge,
  // with the DUT idle. waits[k] = wait states inserted before beat k's ack.
  task automatic run_txn(input logic [63:0] adr, input logic [63:0] dat,
                         input logic we, input logic [1:0] siz,
                         input logic sgn, input logic keep);
    int          nb, nbeat;
    logic [63:0] base, v;
    logic [62:0] ea;
    logic [15:0] ewd;
    logic [1:0]  esel;
    nb    = 1 << siz;
    nbeat = (nb == 1) ? 1 : nb / 2;
    base  = adr & ~(64'(nb) - 64'd1);
    v = '0;
    for (int i = 0; i < nb; i++) v |= 64'(rd_byte(base + 64'(i))) << (8 * i);
    if (sgn && nb < 8 && v[8*nb-1]) v |= ~64'd0 << (8 * nb);
    esel = (nb == 1) ? {adr[0], ~adr[0]} : 2'b11;

    dadr_i = adr; ddat_i = dat; dwe_i = we; dsiz_i = siz; dsigned_i = sgn;
    dcyc_i = 1'b1; dstb_i = 1'b1;
    wack_i = 1'($urandom);            // must be ignored while idle
    @(posedge clk_i); #1;
    // CPU-side changes must be ignored until the transaction completes.
    dadr_i = {$urandom, $urandom}; ddat_i = {$urandom, $urandom};
    dwe_i = 1'($urandom); dsiz_i = 2'($urandom); dsigned_i = 1'($urandom);
    if (!keep) begin dcyc_i = 1'b0; dstb_i = 1'b0; end
    for (int k = 0; k < nbeat; k++) begin
      ea  = base[63:1] + 63'(k);
      ewd = (nb == 1) ? {dat[7:0], dat[7:0]} : 16'(dat >> (16 * k));
      for (int w = 0; w <= waits[k]; w++) begin
        chk("wcyc", {63'd0, wcyc_o}, 64'd1);
        chk("wstb", {63'd0, wstb_o}, 64'd1);
        chk("wwe",  {63'd0, wwe_o},  {63'd0, we});
        chk("wadr", {1'b0, wadr_o},  {1'b0, ea});
        chk("wsel", {62'd0, wsel_o}, {62'd0, esel});
        if (we) chk("wdat", {48'd0, wdat_o}, {48'd0, ewd});
        chk("dack_busy", {63'd0, dack_o}, 64'd0);
        wack_i = (w == waits[k]);
        wdat_i = wack_i ? memhw(ea) : 16'($urandom);
        @(posedge clk_i); #1;
      end
    end
    wack_i = 1'($urandom);            // ignored in DONE
    if (!we) exp_ddat = v;
    exp_dacks++;
    chk("dack", {63'd0, dack_o}, 64'd1);
    chk("done_cyc", {62'd0, wcyc_o, wstb_o}, 64'd0);
    chk("ddat", ddat_o, exp_ddat);
    @(posedge clk_i); #1;
    wack_i = 1'b0;
    chk("dack_pulse", {63'd0, dack_o}, 64'd0);
    chk("ddat_hold", ddat_o, exp_ddat);
  endtask

  initial begin
    int snap;
    logic [1:0] s;
    reset_i = 1'b1; dadr_i = '0; ddat_i = '0; dwe_i = 1'b0; dcyc_i = 1'b0;
    dstb_i = 1'b0; dsiz_i = 2'd0; dsigned_i = 1'b0; wdat_i = '0; wack_i = 1'b0;
    waits = '{0, 0, 0, 0};
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk_idle_outputs("reset");

    // Byte store to an odd address.
    run_txn(64'h1001, 64'hAB, 1'b1, 2'd0, 1'b0, 1'b0);

    // Half load 0x8001, signed then unsigned.
    mem[63'h1001] = 16'h8001;
    run_txn(64'h2002, 64'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    chk("half_signed", ddat_o, 64'hFFFF_FFFF_FFFF_8001);
    run_txn(64'h2002, 64'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    chk("half_unsigned", ddat_o, 64'h0000_0000_0000_8001);

    // Dword load, two wait states on the second beat.
    mem[63'h1800] = 16'h1111; mem[63'h1801] = 16'h2222;
    mem[63'h1802] = 16'h3333; mem[63'h1803] = 16'h4444;
    waits = '{0, 2, 0, 0};
    run_txn(64'h3000, 64'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    chk("dword", ddat_o, 64'h4444_3333_2222_1111);
    waits = '{0, 0, 0, 0};

    // Misaligned word store is aligned down, not split.
    run_txn(64'h4003, 64'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 1'b0);

    // Back-to-back: request held high through DONE.
    run_txn(64'h6005, 64'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    run_txn(64'h7006, 64'h0, 1'b0, 2'd2, 1'b1, 1'b0);

    // Reset in the middle of a dword load.
    snap = dack_cnt;
    dadr_i = 64'h5008; dsiz_i = 2'd3; dwe_i = 1'b0; dsigned_i = 1'b0;
    dcyc_i = 1'b1; dstb_i = 1'b1;
    @(posedge clk_i); #1;
    dcyc_i = 1'b0; dstb_i = 1'b0;
    wack_i = 1'b1; wdat_i = 16'hCAFE;
    repeat (2) begin @(posedge clk_i); #1; end
    chk("mid_wadr", {1'b0, wadr_o}, 64'h2806);
    wack_i = 1'b0; reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    exp_ddat = '0;
    chk_idle_outputs("mid_reset");
    wack_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("post_reset_cyc", {63'd0, wcyc_o}, 64'd0);
    end
    wack_i = 1'b0;
    chk("no_dack_after_reset", 64'(dack_cnt), 64'(snap));
    run_txn(64'h9003, 64'h0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) waits[k] = $urandom_range(0, 2);
      s = 2'($urandom);
      run_txn({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), s,
              1'($urandom), (i < 39) ? 1'($urandom) : 1'b0);
    end

    repeat (2) @(posedge clk_i);
    #1;
    chk("dack_count", 64'(dack_cnt), 64'(exp_dacks));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
